// File: rtl/antenna_array_tx.sv
// -----------------------------------------------------------------------------
// antenna_array_tx
//   Multi-channel framed transmitter. Each accepted payload word becomes a
//   frame of PREAMBLE_LEN alternating preamble symbols followed by WORD_W data
//   symbols (MSB first). Every symbol is modulated (OOK level, OOK carrier or
//   Manchester) and driven onto NUM_CH replicated conductive loops.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   s_valid/ready - payload handshake, s_data is the payload word
//   mode          - 0 level OOK, 1 carrier OOK, 2 Manchester, 3 as 0
//   ch_en         - per-loop enable, latched at accept
//   abort         - synchronous frame abort (ignored when idle)
//   busy          - frame in progress
//   sym_strobe    - high on the last cycle of every symbol
//   done          - one-cycle pulse after a normally completed frame
//   ant_drive     - registered per-loop excitation
//   ant_sense     - per-loop OR of its LOOP_LEN replicated segments
// -----------------------------------------------------------------------------
module antenna_array_tx #(
    parameter int NUM_CH       = 4,
    parameter int LOOP_LEN     = 1000,
    parameter int WORD_W       = 8,
    parameter int SYM_CYCLES   = 1000,
    parameter int CARRIER_DIV  = 2,
    parameter int PREAMBLE_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic [1:0]        mode,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              abort,
    output logic              busy,
    output logic              sym_strobe,
    output logic              done,
    output logic [NUM_CH-1:0] ant_drive,
    output logic [NUM_CH-1:0] ant_sense
);

    localparam int SW      = $clog2(SYM_CYCLES);
    localparam int BIT_MAX = (WORD_W > PREAMBLE_LEN) ? WORD_W : PREAMBLE_LEN;
    localparam int BW      = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
    localparam int CW      = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_CYCLES - 1);
    localparam logic [SW-1:0] SYM_HALF = SW'(SYM_CYCLES / 2);
    localparam logic [BW-1:0] PRE_LAST = BW'(PREAMBLE_LEN - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(WORD_W - 1);
    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [1:0] MODE_CARRIER = 2'd1;
    localparam logic [1:0] MODE_MANCH   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     sym_cnt_q, sym_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     car_cnt_q, car_cnt_d;
    logic              car_ph_q, car_ph_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [1:0]        mode_q, mode_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              sym_strobe_q, sym_strobe_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] ant_drive_q, ant_drive_d;
    logic              strobe_s;
    logic              sym_bit_s;
    logic              mod_s;

    // All registered outputs are computed from next-state values so that the
    // first preamble cycle is visible directly after the accepting edge.

    // Frame FSM, symbol counter, bit counter and shadow registers.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        mode_d    = mode_q;
        ch_en_d   = ch_en_q;
        done_d    = 1'b0;
        strobe_s  = (sym_cnt_q == SYM_LAST);
        case (state_q)
            ST_IDLE: begin
                sym_cnt_d = '0;
                bit_cnt_d = '0;
                if (s_valid && s_ready_q) begin
                    state_d = ST_PRE;
                    data_d  = s_data;
                    mode_d  = mode;
                    ch_en_d = ch_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE, ST_DATA: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    sym_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (strobe_s) begin
                    sym_cnt_d = '0;
                    if (state_q == ST_PRE) begin
                        if (bit_cnt_q == PRE_LAST) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = BIT_MSB;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        if (bit_cnt_q == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                end else begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Carrier phase: restarts high at the first cycle of every symbol.
    always_comb begin
        car_cnt_d = car_cnt_q;
        car_ph_d  = car_ph_q;
        if ((state_d == ST_IDLE) || (sym_cnt_d == '0)) begin
            car_cnt_d = '0;
            car_ph_d  = 1'b1;
        end else if (car_cnt_q == CAR_LAST) begin
            car_cnt_d = '0;
            car_ph_d  = ~car_ph_q;
        end else begin
            car_cnt_d = car_cnt_q + 1'b1;
        end
    end

    // Symbol value selection, modulation and output gating.
    always_comb begin
        sym_bit_s = 1'b0;
        mod_s     = 1'b0;
        if (state_d == ST_PRE) begin
            // Preamble index 0 is a 1, so even indices send 1.
            sym_bit_s = ~bit_cnt_d[0];
        end else if (state_d == ST_DATA) begin
            sym_bit_s = |(data_d & (WORD_W'(1) << bit_cnt_d));
        end else begin
            sym_bit_s = 1'b0;
        end
        case (mode_d)
            MODE_CARRIER: mod_s = sym_bit_s & car_ph_d;
            MODE_MANCH:   mod_s = (sym_cnt_d < SYM_HALF) ? sym_bit_s : ~sym_bit_s;
            default:      mod_s = sym_bit_s;
        endcase
        // Manchester idles at 0 too, so gate on state rather than on the bit.
        if (state_d != ST_IDLE) begin
            ant_drive_d = {NUM_CH{mod_s}} & ch_en_d;
        end else begin
            ant_drive_d = '0;
        end
        s_ready_d    = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        sym_strobe_d = busy_d && (sym_cnt_d == SYM_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            car_cnt_q    <= '0;
            car_ph_q     <= 1'b0;
            data_q       <= '0;
            mode_q       <= 2'd0;
            ch_en_q      <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            sym_strobe_q <= 1'b0;
            done_q       <= 1'b0;
            ant_drive_q  <= '0;
        end else begin
            state_q      <= state_d;
            sym_cnt_q    <= sym_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            car_cnt_q    <= car_cnt_d;
            car_ph_q     <= car_ph_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            ch_en_q      <= ch_en_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            sym_strobe_q <= sym_strobe_d;
            done_q       <= done_d;
            ant_drive_q  <= ant_drive_d;
        end
    end

    // Replicated loop segments; each is kept as a distinct net per loop.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_loop
        (* keep = "true" *) logic [LOOP_LEN-1:0] seg_s;
        assign seg_s         = {LOOP_LEN{ant_drive_q[ch]}};
        assign ant_sense[ch] = |seg_s;
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign sym_strobe = sym_strobe_q;
    assign done       = done_q;
    assign ant_drive  = ant_drive_q;

endmodule
